// File: rtl/pwm_ctrl_pkg.sv
// Shared PWM-side types and constants: 16-bit PWM value width, ramp FSM states and
// the saturating step helper used by the ramp controller.
package pwm_ctrl_pkg;

   localparam int unsigned PwmW  = 16;
   localparam int unsigned HoldW = 8;

   typedef logic [PwmW-1:0]  pwm_val_t;
   typedef logic [HoldW-1:0] hold_val_t;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StArmed = 2'd1,
      StRamp  = 2'd2
   } ramp_state_e;

   function automatic pwm_val_t min_val(input pwm_val_t a, input pwm_val_t b);
      return (a < b) ? a : b;
   endfunction

   // Move cur toward tgt by step without overshoot; 17-bit math so neither direction wraps.
   function automatic pwm_val_t step_toward(input pwm_val_t cur, input pwm_val_t tgt,
                                            input pwm_val_t step);
      logic [PwmW:0] sum;
      logic [PwmW:0] diff;
      sum  = {1'b0, cur} + {1'b0, step};
      diff = {1'b0, cur} - {1'b0, step};
      if (step == '0) begin
         return tgt;
      end else if (cur < tgt) begin
         return (sum >= {1'b0, tgt}) ? tgt : sum[PwmW-1:0];
      end else if (cur > tgt) begin
         return (diff[PwmW] || (diff[PwmW-1:0] <= tgt)) ? tgt : diff[PwmW-1:0];
      end
      return tgt;
   endfunction

endpackage

// File: rtl/pwm_period_tracker.sv
// Shadow of the PWM counter: counts 0..period-1 and flags the boundary tick on the
// cycle the counter wraps, so period/duty updates land exactly at counter 0.
module pwm_period_tracker
   import pwm_ctrl_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [PwmW-1:0] period_i,
   output logic            tick_o
);

   pwm_val_t cnt_q, cnt_d;
   pwm_val_t last_cnt;

   // Modulo-16 subtraction: period 0 behaves as a 65536-cycle period.
   assign last_cnt = period_i - PwmW'(1);

   always_comb begin
      tick_o = (cnt_q >= last_cnt);
      cnt_d  = tick_o ? '0 : cnt_q + PwmW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM period/duty ramp controller. Define PWM_RAMP_ABORT_EN to let a new request
// replace a ramp in progress; otherwise requests are held off until the block is idle.
module pwm_ramp_ctrl
   import pwm_ctrl_pkg::*;
#(
   parameter logic [PwmW-1:0] DEFAULT_PERIOD = 16'd1000,
   parameter logic [PwmW-1:0] DEFAULT_DUTY   = 16'd0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [PwmW-1:0]  cfg_period,
   input  logic [PwmW-1:0]  cfg_target,
   input  logic [PwmW-1:0]  cfg_step,
   input  logic [HoldW-1:0] cfg_hold,
   output logic [PwmW-1:0]  period,
   output logic [PwmW-1:0]  duty_cycle,
   output logic             busy,
   output logic             done
);

   ramp_state_e state_q, state_d;
   logic        tick;
   logic        accept;
   pwm_val_t    step_res;

   pwm_val_t  sh_period_q, sh_period_d;
   pwm_val_t  sh_target_q, sh_target_d;
   pwm_val_t  sh_step_q, sh_step_d;
   hold_val_t sh_hold_q, sh_hold_d;
   hold_val_t hold_q, hold_d;
   pwm_val_t  target_q, target_d;
   pwm_val_t  period_q, period_d;
   pwm_val_t  duty_q, duty_d;
   logic      done_q, done_d;

   pwm_period_tracker u_tracker (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .period_i (period_q),
      .tick_o   (tick)
   );

   assign accept   = cfg_valid && cfg_ready;
   assign step_res = step_toward(duty_q, target_q, sh_step_q);

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StArmed;
         StArmed: if (tick) state_d = StRamp;
         StRamp:  if (tick && (hold_q == '0) && (step_res == target_q)) state_d = StIdle;
         default: state_d = StIdle;
      endcase
`ifdef PWM_RAMP_ABORT_EN
      if (accept) state_d = StArmed;
`endif
   end

   // Output logic
   always_comb begin
`ifdef PWM_RAMP_ABORT_EN
      cfg_ready = 1'b1;
`else
      cfg_ready = (state_q == StIdle);
`endif
      busy = (state_q != StIdle);
   end

   assign period     = period_q;
   assign duty_cycle = duty_q;
   assign done       = done_q;

   // Datapath; an accept takes priority over any boundary work on the same edge.
   always_comb begin
      sh_period_d = sh_period_q;
      sh_target_d = sh_target_q;
      sh_step_d   = sh_step_q;
      sh_hold_d   = sh_hold_q;
      hold_d      = hold_q;
      target_d    = target_q;
      period_d    = period_q;
      duty_d      = duty_q;
      done_d      = 1'b0;

      if (accept) begin
         sh_period_d = cfg_period;
         sh_target_d = cfg_target;
         sh_step_d   = cfg_step;
         sh_hold_d   = cfg_hold;
      end else if (tick) begin
         unique case (state_q)
            StArmed: begin
               period_d = sh_period_q;
               target_d = min_val(sh_target_q, sh_period_q);
               duty_d   = min_val(duty_q, sh_period_q);
               hold_d   = sh_hold_q;
            end
            StRamp: begin
               if (hold_q != '0) begin
                  hold_d = hold_q - HoldW'(1);
               end else begin
                  duty_d = step_res;
                  hold_d = sh_hold_q;
                  done_d = (step_res == target_q);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sh_period_q <= '0;
         sh_target_q <= '0;
         sh_step_q   <= '0;
         sh_hold_q   <= '0;
         hold_q      <= '0;
         target_q    <= '0;
         period_q    <= DEFAULT_PERIOD;
         duty_q      <= DEFAULT_DUTY;
         done_q      <= 1'b0;
      end else begin
         sh_period_q <= sh_period_d;
         sh_target_q <= sh_target_d;
         sh_step_q   <= sh_step_d;
         sh_hold_q   <= sh_hold_d;
         hold_q      <= hold_d;
         target_q    <= target_d;
         period_q    <= period_d;
         duty_q      <= duty_d;
         done_q      <= done_d;
      end
   end

endmodule
